on_the_fly_node2noc: RTL and testbench

//  Pending-transaction table on the node-to-NoC path of the NIC. Each entry records an in-flight
//  (sender, recipient, command) tuple. A combinational query reports whether a tuple is pending.
//  The same query can retire the matching entry. Blocks use it to match responses to outstanding requests.

---
 rtl/on_the_fly_node2noc.sv | 108 ++++++++++
 tb/tb_on_the_fly_node2noc.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/on_the_fly_node2noc.sv
// Pending-transaction table for the node-to-NoC path.
// Holds DEPTH in-flight (sender, recipient, command) tuples. A combinational query reports
// whether a tuple is present, and the same query can optionally retire the matching entry.
module on_the_fly_node2noc #(
    parameter int unsigned N_BITS_POINTER = 2,
    parameter int unsigned N_BIT_SRC      = 4,
    parameter int unsigned N_BIT_DEST     = 4,
    parameter int unsigned N_BIT_CMD      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_pending_transaction_i,
    input  logic [N_BIT_SRC-1:0]  new_sender_i,
    input  logic [N_BIT_DEST-1:0] new_recipient_i,
    input  logic [N_BIT_CMD-1:0]  new_transaction_type_i,
    input  logic                  query_i,
    input  logic [N_BIT_SRC-1:0]  query_sender_i,
    input  logic [N_BIT_DEST-1:0] query_recipient_i,
    input  logic [N_BIT_CMD-1:0]  query_transaction_type_i,
    input  logic                  delete_transaction_i,
    output logic                  is_a_pending_transaction_o
);

    localparam int unsigned DEPTH = 2 ** N_BITS_POINTER;

    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0][N_BIT_SRC-1:0]  src_q, src_d;
    logic [DEPTH-1:0][N_BIT_DEST-1:0] dest_q, dest_d;
    logic [DEPTH-1:0][N_BIT_CMD-1:0]  cmd_q, cmd_d;

    logic [DEPTH-1:0]          hit;
    logic                      any_hit;
    logic [N_BITS_POINTER-1:0] hit_idx;
    logic                      any_free;
    logic [N_BITS_POINTER-1:0] free_idx;
    logic                      do_insert;
    logic                      do_delete;

    // Per-entry match against the query tuple
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid_q[i]
                   && (src_q[i]  == query_sender_i)
                   && (dest_q[i] == query_recipient_i)
                   && (cmd_q[i]  == query_transaction_type_i);
        end
    end

    assign any_hit  = |hit;
    assign any_free = ~&valid_q;

    // Lowest-index hit and lowest-index free slot; descending scan so the lowest wins
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = N_BITS_POINTER'(i);
            end
            if (!valid_q[i]) begin
                free_idx = N_BITS_POINTER'(i);
            end
        end
    end

    assign is_a_pending_transaction_o = query_i & any_hit;

    // Free slot comes from pre-edge state, so a slot retired this cycle is never the insert
    // target; a full table drops the insert even when a delete happens alongside it.
    assign do_insert = new_pending_transaction_i & any_free;
    assign do_delete = query_i & delete_transaction_i & any_hit;

    // Next-state: insert into the free slot and retire the hit slot; the two never coincide
    // because a hit slot is always valid and the free slot is always invalid.
    always_comb begin
        valid_d = valid_q;
        src_d   = src_q;
        dest_d  = dest_q;
        cmd_d   = cmd_q;
        if (do_insert) begin
            valid_d[free_idx] = 1'b1;
            src_d[free_idx]   = new_sender_i;
            dest_d[free_idx]  = new_recipient_i;
            cmd_d[free_idx]   = new_transaction_type_i;
        end
        if (do_delete) begin
            valid_d[hit_idx] = 1'b0;
        end
    end

    // Valid bits: reset empties the table and overrides any insert/delete
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tuple fields: contents are meaningless while the entry is invalid, so no reset
    always_ff @(posedge clk) begin
        src_q  <= src_d;
        dest_q <= dest_d;
        cmd_q  <= cmd_d;
    end

endmodule

// File: tb/tb_on_the_fly_node2noc.sv
// Bench for on_the_fly_node2noc: one-cycle directed vectors plus a duplicate-retire sequence.
module tb_on_the_fly_node2noc;

    logic       clk = 1'b0;
    logic       rst;
    logic       ins;
    logic [3:0] ns, nr;
    logic [2:0] nc;
    logic       q;
    logic [3:0] qs, qr;
    logic [2:0] qc;
    logic       del;
    logic       out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    on_the_fly_node2noc dut (
        .clk                        (clk),
        .rst                        (rst),
        .new_pending_transaction_i  (ins),
        .new_sender_i               (ns),
        .new_recipient_i            (nr),
        .new_transaction_type_i     (nc),
        .query_i                    (q),
        .query_sender_i             (qs),
        .query_recipient_i          (qr),
        .query_transaction_type_i   (qc),
        .delete_transaction_i       (del),
        .is_a_pending_transaction_o (out)
    );

    typedef struct {
        logic       rst;
        logic       ins;
        logic [3:0] ns;
        logic [3:0] nr;
        logic [2:0] nc;
        logic       q;
        logic [3:0] qs;
        logic [3:0] qr;
        logic [2:0] qc;
        logic       del;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic i, input int s, input int d,
                                input int c, input logic qe, input int a, input int b,
                                input int e, input logic dl, input logic x);
        vec_t v;
        v.rst = r;  v.ins = i;
        v.ns  = 4'(s); v.nr = 4'(d); v.nc = 3'(c);
        v.q   = qe;
        v.qs  = 4'(a); v.qr = 4'(b); v.qc = 3'(e);
        v.del = dl; v.exp = x;
        return v;
    endfunction

    // Drive one cycle's inputs after the falling edge, check the combinational output before
    // the next rising edge commits the cycle.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst = v.rst; ins = v.ins; ns = v.ns; nr = v.nr; nc = v.nc;
        q = v.q; qs = v.qs; qr = v.qr; qc = v.qc; del = v.del;
        #1;
        checks++;
        if (out !== v.exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, out, v.exp);
        end
    endtask

    initial begin
        rst = 1'b1; ins = 1'b0; ns = '0; nr = '0; nc = '0;
        q = 1'b0; qs = '0; qr = '0; qc = '0; del = 1'b0;

        //                rst ins ns nr nc  q  qs qr qc del exp
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0)); // 0 reset
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0)); // 1 reset
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0)); // 2 empty table
        vecs.push_back(mk(0, 1, 1, 2, 0, 1, 1, 2, 0, 0, 0)); // 3 insert not yet visible
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 1)); // 4 hit
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 1, 0, 0)); // 5 cmd differs
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0)); // 6 query_i low
        vecs.push_back(mk(0, 1, 2, 2, 0, 1, 1, 2, 0, 1, 1)); // 7 delete + insert same edge
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0)); // 8 deleted
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 1)); // 9 inserted
        vecs.push_back(mk(0, 1, 3, 2, 0, 1, 3, 2, 0, 0, 0)); // 10 zero-latency, not yet
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 2, 0, 0, 1)); // 11 visible
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 2, 0, 0, 1)); // 12 rst cycle, still pre-edge
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 2, 0, 0, 0)); // 13 emptied
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // 14 fill
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1)); // 15
        vecs.push_back(mk(0, 1, 2, 2, 2, 0, 0, 0, 0, 0, 0)); // 16
        vecs.push_back(mk(0, 1, 3, 3, 3, 1, 2, 2, 2, 0, 1)); // 17
        vecs.push_back(mk(0, 1, 5, 5, 5, 1, 3, 3, 3, 0, 1)); // 18 full: insert dropped
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 5, 5, 5, 0, 0)); // 19
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1)); // 20
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1)); // 21
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 2, 2, 0, 1)); // 22
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 3, 3, 0, 1)); // 23
        vecs.push_back(mk(0, 1, 5, 5, 5, 1, 1, 1, 1, 1, 1)); // 24 full: del + ins, ins dropped
        vecs.push_back(mk(0, 1, 5, 5, 5, 1, 5, 5, 5, 0, 0)); // 25 not stored; insert now
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 5, 5, 5, 0, 1)); // 26 stored in freed slot
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0)); // 27 (1,1,1) gone
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1)); // 28 free slot 0
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 2, 2, 1, 1)); // 29 free slot 2
        vecs.push_back(mk(0, 1, 7, 7, 7, 1, 7, 7, 7, 0, 0)); // 30 dup insert #1
        vecs.push_back(mk(0, 1, 7, 7, 7, 1, 7, 7, 7, 0, 1)); // 31 dup insert #2
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7, 7, 7, 1, 1)); // 32 first delete
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7, 7, 7, 1, 1)); // 33 one copy left
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7, 7, 7, 0, 0)); // 34 both gone
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 3, 3, 1, 0)); // 35 delete without query_i
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 3, 3, 0, 1)); // 36 still present
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 6, 6, 6, 1, 0)); // 37 delete with no hit
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 5, 5, 5, 0, 1)); // 38 unaffected
        vecs.push_back(mk(0, 1, 4, 4, 4, 0, 0, 0, 0, 0, 0)); // 39 refill
        vecs.push_back(mk(0, 1, 6, 6, 6, 1, 4, 4, 4, 0, 1)); // 40 table full now
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 6, 6, 6, 0, 1)); // 41 rst beats insert
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 6, 6, 6, 0, 0)); // 42
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 3, 3, 0, 0)); // 43
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0)); // 44 insert under rst dropped
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 5, 5, 5, 0, 0)); // 45

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Four copies of one tuple retire one per cycle, lowest first
        for (int i = 0; i < 4; i++) begin
            apply(mk(0, 1, 9, 9, 1, 0, 0, 0, 0, 0, 0), $sformatf("dup_fill%0d", i));
        end
        apply(mk(0, 1, 2, 2, 2, 1, 2, 2, 2, 0, 0), "dup_full_drop");
        for (int i = 0; i < 4; i++) begin
            apply(mk(0, 0, 0, 0, 0, 1, 9, 9, 1, 1, 1), $sformatf("dup_del%0d", i));
        end
        apply(mk(0, 0, 0, 0, 0, 1, 9, 9, 1, 0, 0), "dup_all_gone");
        apply(mk(0, 0, 0, 0, 0, 1, 2, 2, 2, 0, 0), "dup_dropped_absent");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
